// File: rtl/pe_cfg_pkg.sv
// Shared types, array geometry and mapping helpers for the PE-array configuration sequencer.
// PE_ARRAY_CFG_CHECK_EN (in the top) is the only build option; cfg_legal serves it.
package pe_cfg_pkg;

   localparam int NUMS_PE_ROW = 6;
   localparam int NUMS_PE_COL = 8;
   localparam int XID_BITS    = 5;
   localparam int YID_BITS    = 3;
   localparam int CONFIG_SIZE = 10;

   localparam int NUMS_PE  = NUMS_PE_ROW * NUMS_PE_COL;
   localparam int IDX_BITS = $clog2(NUMS_PE);
   localparam int ROW_BITS = $clog2(NUMS_PE_ROW);

   // All-ones IDs are never matched by any tag on the array networks.
   localparam logic [XID_BITS-1:0] ID_NONE_X = '1;
   localparam logic [YID_BITS-1:0] ID_NONE_Y = '1;

   typedef enum logic [2:0] {
      IDLE,
      SCAN_X,
      SCAN_Y,
      SET_LN,
      SET_CFG,
      DONE
   } state_t;

   typedef struct packed {
      logic [3:0] e;
      logic [2:0] r;
      logic [2:0] t;
   } map_t;

   function automatic logic cfg_legal(map_t m);
      return (m.e != '0) && (int'(m.e) <= NUMS_PE_COL) &&
             (m.r != '0) && (m.t != '0) &&
             (int'(m.r) * int'(m.t) <= NUMS_PE_ROW);
   endfunction

   // Row y forwards its psum down from row y+1 unless it is the last row of its set.
   function automatic logic [NUMS_PE_ROW-2:0] ln_links(map_t m);
      logic [NUMS_PE_ROW-2:0] ln;
      int rt;
      ln = '0;
      rt = int'(m.r) * int'(m.t);
      for (int y = 0; y < NUMS_PE_ROW-1; y++) begin
         if (m.r != '0 && y < rt && (y % int'(m.r)) != int'(m.r) - 1)
            ln[y] = 1'b1;
      end
      return ln;
   endfunction

endpackage

// File: rtl/pe_id_gen.sv
// Combinational ID generator: for one PE index and a layer mapping, returns the
// four network XIDs, the four YIDs of that PE's row, and the PE enable.
module pe_id_gen
   import pe_cfg_pkg::*;
(
   input  logic [IDX_BITS-1:0] idx,
   input  map_t                map,
   output logic [XID_BITS-1:0] ifmap_xid,
   output logic [XID_BITS-1:0] filter_xid,
   output logic [XID_BITS-1:0] ipsum_xid,
   output logic [XID_BITS-1:0] opsum_xid,
   output logic [YID_BITS-1:0] ifmap_yid,
   output logic [YID_BITS-1:0] filter_yid,
   output logic [YID_BITS-1:0] ipsum_yid,
   output logic [YID_BITS-1:0] opsum_yid,
   output logic                en
);

   int   x_i;
   int   y_i;
   int   rt_i;
   int   k_i;
   int   m_i;
   logic row_act;

   always_comb begin
      x_i     = int'(idx) % NUMS_PE_COL;
      y_i     = int'(idx) / NUMS_PE_COL;
      rt_i    = int'(map.r) * int'(map.t);
      k_i     = 0;
      m_i     = 0;
      // With r == 0 no row is active, so k and m are never looked at.
      if (map.r != '0) begin
         k_i = y_i / int'(map.r);
         m_i = y_i % int'(map.r);
      end
      row_act = (y_i < rt_i);
      en      = row_act && (x_i < int'(map.e));
   end

   always_comb begin
      ifmap_xid  = ID_NONE_X;
      filter_xid = ID_NONE_X;
      ipsum_xid  = ID_NONE_X;
      opsum_xid  = ID_NONE_X;
      if (en) begin
         ifmap_xid  = XID_BITS'(x_i + m_i);
         filter_xid = '0;
         ipsum_xid  = XID_BITS'(x_i);
         opsum_xid  = XID_BITS'(x_i);
      end
   end

   always_comb begin
      ifmap_yid  = ID_NONE_Y;
      filter_yid = ID_NONE_Y;
      ipsum_yid  = ID_NONE_Y;
      opsum_yid  = ID_NONE_Y;
      if (row_act) begin
         ifmap_yid  = YID_BITS'(y_i);
         filter_yid = YID_BITS'(y_i);
         // ipsum enters at the bottom row of a set, opsum leaves from the top row.
         if (m_i == int'(map.r) - 1) ipsum_yid = YID_BITS'(k_i);
         if (m_i == 0)               opsum_yid = YID_BITS'(k_i);
      end
   end

endmodule

// File: rtl/pe_array_cfg_seq.sv
// PE-array configuration sequencer: scans XIDs then YIDs, loads LN links, then PE_en/PE_config.
// Build option PE_ARRAY_CFG_CHECK_EN adds an `error` output and rejects illegal mappings.
module pe_array_cfg_seq
   import pe_cfg_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [3:0]                           cfg_e,
   input  logic [2:0]                           cfg_r,
   input  logic [2:0]                           cfg_t,
   input  logic [CONFIG_SIZE-1:0]               cfg_pe_config,
   output logic                                 busy,
   output logic                                 done,
`ifdef PE_ARRAY_CFG_CHECK_EN
   output logic                                 error,
`endif
   output logic                                 set_XID,
   output logic [XID_BITS-1:0]                  ifmap_XID_scan_in,
   output logic [XID_BITS-1:0]                  filter_XID_scan_in,
   output logic [XID_BITS-1:0]                  ipsum_XID_scan_in,
   output logic [XID_BITS-1:0]                  opsum_XID_scan_in,
   output logic                                 set_YID,
   output logic [YID_BITS-1:0]                  ifmap_YID_scan_in,
   output logic [YID_BITS-1:0]                  filter_YID_scan_in,
   output logic [YID_BITS-1:0]                  ipsum_YID_scan_in,
   output logic [YID_BITS-1:0]                  opsum_YID_scan_in,
   output logic                                 set_LN,
   output logic [NUMS_PE_ROW-2:0]               LN_config_in,
   output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]   PE_en,
   output logic [CONFIG_SIZE-1:0]               PE_config
);

   state_t                 state;
   state_t                 state_nx;
   logic [IDX_BITS-1:0]    count;
   map_t                   map_in;
   map_t                   map_q;
   logic [CONFIG_SIZE-1:0] pe_config_q;
   logic [NUMS_PE-1:0]     en_acc;
   logic                   accept;
   logic                   cfg_ok;
   logic [ROW_BITS-1:0]    scan_row;
   logic [IDX_BITS-1:0]    gen_idx;

   logic [XID_BITS-1:0]    g_ifx, g_fx, g_ipx, g_opx;
   logic [YID_BITS-1:0]    g_ify, g_fy, g_ipy, g_opy;
   logic                   g_en;

   assign map_in = '{e: cfg_e, r: cfg_r, t: cfg_t};
   assign accept = (state == IDLE) && start;

`ifdef PE_ARRAY_CFG_CHECK_EN
   logic err_q;

   assign cfg_ok = cfg_legal(map_in);
   assign error  = (state == DONE) && err_q;

   always_ff @(posedge clk) begin
      if (!rst)        err_q <= 1'b0;
      else if (accept) err_q <= !cfg_ok;
   end
`else
   assign cfg_ok = 1'b1;
`endif

   // X scan walks PE indices from the far end down; Y scan uses column 0 of each row.
   assign scan_row = ROW_BITS'(NUMS_PE_ROW-1) - count[ROW_BITS-1:0];
   assign gen_idx  = (state == SCAN_Y) ? IDX_BITS'(int'(scan_row) * NUMS_PE_COL)
                                       : IDX_BITS'(NUMS_PE-1) - count;

   pe_id_gen u_id_gen (
      .idx        (gen_idx),
      .map        (map_q),
      .ifmap_xid  (g_ifx),
      .filter_xid (g_fx),
      .ipsum_xid  (g_ipx),
      .opsum_xid  (g_opx),
      .ifmap_yid  (g_ify),
      .filter_yid (g_fy),
      .ipsum_yid  (g_ipy),
      .opsum_yid  (g_opy),
      .en         (g_en)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = cfg_ok ? SCAN_X : DONE;
         SCAN_X:  if (count == IDX_BITS'(NUMS_PE-1)) state_nx = SCAN_Y;
         SCAN_Y:  if (count == IDX_BITS'(NUMS_PE_ROW-1)) state_nx = SET_LN;
         SET_LN:  state_nx = SET_CFG;
         SET_CFG: state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy               = 1'b0;
      done               = 1'b0;
      set_XID            = 1'b0;
      set_YID            = 1'b0;
      set_LN             = 1'b0;
      ifmap_XID_scan_in  = '0;
      filter_XID_scan_in = '0;
      ipsum_XID_scan_in  = '0;
      opsum_XID_scan_in  = '0;
      ifmap_YID_scan_in  = '0;
      filter_YID_scan_in = '0;
      ipsum_YID_scan_in  = '0;
      opsum_YID_scan_in  = '0;
      LN_config_in       = '0;
      case (state)
         SCAN_X: begin
            busy               = 1'b1;
            set_XID            = 1'b1;
            ifmap_XID_scan_in  = g_ifx;
            filter_XID_scan_in = g_fx;
            ipsum_XID_scan_in  = g_ipx;
            opsum_XID_scan_in  = g_opx;
         end
         SCAN_Y: begin
            busy               = 1'b1;
            set_YID            = 1'b1;
            ifmap_YID_scan_in  = g_ify;
            filter_YID_scan_in = g_fy;
            ipsum_YID_scan_in  = g_ipy;
            opsum_YID_scan_in  = g_opy;
         end
         SET_LN: begin
            busy         = 1'b1;
            set_LN       = 1'b1;
            LN_config_in = ln_links(map_q);
         end
         SET_CFG: busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         count       <= '0;
         map_q       <= '0;
         pe_config_q <= '0;
         en_acc      <= '0;
         PE_en       <= '0;
         PE_config   <= '0;
      end else begin
         state <= state_nx;
         count <= (state_nx != state || state == IDLE) ? '0 : count + 1'b1;
         if (accept) begin
            map_q       <= map_in;
            pe_config_q <= cfg_pe_config;
            if (cfg_ok) PE_en <= '0;
         end
         // Enables arrive highest index first, so shifting left lands PE 0 at bit 0.
         if (state == SCAN_X) en_acc <= {en_acc[NUMS_PE-2:0], g_en};
         if (state == SET_CFG) begin
            PE_en     <= en_acc;
            PE_config <= pe_config_q;
         end
      end
   end

endmodule

// File: tb/tb_pe_array_cfg_seq.sv
// Self-checking bench for pe_array_cfg_seq: per-cycle reference trace built from the
// mapping rules, plus directed checks; define PE_ARRAY_CFG_CHECK_EN to cover the error port.
module tb_pe_array_cfg_seq;

   localparam int ROWS = 6;
   localparam int COLS = 8;
   localparam int NPE  = ROWS * COLS;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   cfg_e = '0;
   logic [2:0]   cfg_r = '0;
   logic [2:0]   cfg_t = '0;
   logic [9:0]   cfg_pe_config = '0;
   logic         busy, done, set_XID, set_YID, set_LN;
   logic [4:0]   ifmap_XID_scan_in, filter_XID_scan_in, ipsum_XID_scan_in, opsum_XID_scan_in;
   logic [2:0]   ifmap_YID_scan_in, filter_YID_scan_in, ipsum_YID_scan_in, opsum_YID_scan_in;
   logic [4:0]   LN_config_in;
   logic [47:0]  PE_en;
   logic [9:0]   PE_config;
`ifdef PE_ARRAY_CFG_CHECK_EN
   logic         error;
`endif

   // Observation word: busy, done, X strobe + 4 XIDs, Y strobe + 4 YIDs, LN strobe + links.
   logic [41:0]  obs;
   logic [41:0]  exp_q[$];
   logic [41:0]  trace [1:57];
   logic [47:0]  prev_en = '0;
   logic [9:0]   prev_cfg = '0;
   int           vectors = 0;
   int           miscompares = 0;

   assign obs = {busy, done, set_XID, ifmap_XID_scan_in, filter_XID_scan_in, ipsum_XID_scan_in,
                 opsum_XID_scan_in, set_YID, ifmap_YID_scan_in, filter_YID_scan_in,
                 ipsum_YID_scan_in, opsum_YID_scan_in, set_LN, LN_config_in};

   // clock / reset block
   always #5 clk = ~clk;

   pe_array_cfg_seq dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .cfg_e              (cfg_e),
      .cfg_r              (cfg_r),
      .cfg_t              (cfg_t),
      .cfg_pe_config      (cfg_pe_config),
      .busy               (busy),
      .done               (done),
`ifdef PE_ARRAY_CFG_CHECK_EN
      .error              (error),
`endif
      .set_XID            (set_XID),
      .ifmap_XID_scan_in  (ifmap_XID_scan_in),
      .filter_XID_scan_in (filter_XID_scan_in),
      .ipsum_XID_scan_in  (ipsum_XID_scan_in),
      .opsum_XID_scan_in  (opsum_XID_scan_in),
      .set_YID            (set_YID),
      .ifmap_YID_scan_in  (ifmap_YID_scan_in),
      .filter_YID_scan_in (filter_YID_scan_in),
      .ipsum_YID_scan_in  (ipsum_YID_scan_in),
      .opsum_YID_scan_in  (opsum_YID_scan_in),
      .set_LN             (set_LN),
      .LN_config_in       (LN_config_in),
      .PE_en              (PE_en),
      .PE_config          (PE_config)
   );

   // Reference: expected observation word on cycle c after the start edge.
   function automatic logic [41:0] exp_cycle(int c, int e, int r, int t);
      logic [41:0] v;
      int i, x, y, m, k;
      v = '0;
      if (c >= 1 && c <= 56) v[41] = 1'b1;
      if (c == 57) v[40] = 1'b1;
      if (c >= 1 && c <= 48) begin
         i = 48 - c; x = i % COLS; y = i / COLS; m = y % r;
         v[39] = 1'b1;
         if (x < e && y < r * t) begin
            v[38:34] = 5'(x + m);
            v[33:29] = 5'd0;
            v[28:24] = 5'(x);
            v[23:19] = 5'(x);
         end else begin
            v[38:19] = '1;
         end
      end
      if (c >= 49 && c <= 54) begin
         y = 54 - c; k = y / r; m = y % r;
         v[18] = 1'b1;
         if (y < r * t) begin
            v[17:15] = 3'(y);
            v[14:12] = 3'(y);
            v[11:9]  = (m == r - 1) ? 3'(k) : 3'd7;
            v[8:6]   = (m == 0) ? 3'(k) : 3'd7;
         end else begin
            v[17:6] = '1;
         end
      end
      if (c == 55) begin
         v[5] = 1'b1;
         for (int yy = 0; yy < ROWS - 1; yy++)
            if (yy < r * t && (yy % r) != r - 1) v[yy] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [47:0] exp_pe_en(int e, int r, int t);
      logic [47:0] en;
      en = '0;
      for (int i = 0; i < NPE; i++)
         if ((i % COLS) < e && (i / COLS) < r * t) en[i] = 1'b1;
      return en;
   endfunction

   // Driver + scoreboard for one sequence. restart_at pulses start again on that cycle;
   // reset_at pulls rst low on that cycle and ends the sequence there.
   task automatic run_seq(input int e, input int r, input int t, input logic [9:0] pc,
                          input int restart_at, input int reset_at);
      logic [47:0] en_exp;
      logic [41:0] exp_v;
      bit          saw_done;
      exp_q.delete();
      for (int c = 1; c <= 57; c++) exp_q.push_back(exp_cycle(c, e, r, t));
      en_exp = exp_pe_en(e, r, t);
      @(negedge clk);
      cfg_e = 4'(e); cfg_r = 3'(r); cfg_t = 3'(t); cfg_pe_config = pc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 57; c++) begin
         exp_v = exp_q.pop_front();
         trace[c] = obs;
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL outputs e=%0d r=%0d t=%0d cycle=%0d got=%h exp=%h", e, r, t, c, obs, exp_v);
         end
         if (c == 1 || c == 56) begin
            vectors++;
            if (PE_config !== prev_cfg) begin
               miscompares++;
               $display("FAIL pe_config_hold cycle=%0d got=%h exp=%h", c, PE_config, prev_cfg);
            end
         end
         if (c == 2 || c == 56) begin
            vectors++;
            if (PE_en !== 48'h0) begin
               miscompares++;
               $display("FAIL pe_en_cleared cycle=%0d got=%h exp=0", c, PE_en);
            end
         end
         if (c == 57) begin
            vectors++;
            if (PE_en !== en_exp) begin
               miscompares++;
               $display("FAIL pe_en_final got=%h exp=%h", PE_en, en_exp);
            end
            vectors++;
            if (PE_config !== pc) begin
               miscompares++;
               $display("FAIL pe_config_final got=%h exp=%h", PE_config, pc);
            end
`ifdef PE_ARRAY_CFG_CHECK_EN
            vectors++;
            if (error !== 1'b0) begin
               miscompares++;
               $display("FAIL error_on_legal got=%b exp=0", error);
            end
`endif
         end
         if (c == reset_at) begin
            rst = 1'b0;
            @(negedge clk);
            vectors++;
            if (obs !== 42'h0 || PE_en !== 48'h0 || PE_config !== 10'h0) begin
               miscompares++;
               $display("FAIL mid_reset_zero obs=%h pe_en=%h pe_config=%h exp=0", obs, PE_en, PE_config);
            end
            rst = 1'b1;
            saw_done = 1'b0;
            repeat (60) begin
               @(negedge clk);
               if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            end
            vectors++;
            if (saw_done !== 1'b0) begin
               miscompares++;
               $display("FAIL no_done_after_reset got=1 exp=0");
            end
            prev_en = '0;
            prev_cfg = '0;
            return;
         end
         start = (c == restart_at);
         // Scramble the config inputs: the sequencer must use the values latched at start.
         cfg_e = 4'($urandom); cfg_r = 3'($urandom); cfg_t = 3'($urandom);
         cfg_pe_config = 10'($urandom);
         if (c < 57) @(negedge clk);
      end
      start = 1'b0;
      prev_en = en_exp;
      prev_cfg = pc;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (obs !== 42'h0) begin
         miscompares++;
         $display("FAIL reset_outputs got=%h exp=0", obs);
      end
      vectors++;
      if (PE_en !== 48'h0 || PE_config !== 10'h0) begin
         miscompares++;
         $display("FAIL reset_pe got pe_en=%h pe_config=%h exp=0", PE_en, PE_config);
      end
`ifdef PE_ARRAY_CFG_CHECK_EN
      vectors++;
      if (error !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_error got=%b exp=0", error);
      end
`endif
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_map_e8_r3_t2;
      bit bad;
      run_seq(8, 3, 2, 10'h2a5, -1, -1);
      vectors++;
      if (trace[1][38:34] !== 5'd9) begin
         miscompares++;
         $display("FAIL ifmap_xid_pe47 got=%0d exp=9", trace[1][38:34]);
      end
      vectors++;
      if (trace[48][38:34] !== 5'd0) begin
         miscompares++;
         $display("FAIL ifmap_xid_pe0 got=%0d exp=0", trace[48][38:34]);
      end
      bad = 1'b0;
      for (int c = 1; c <= 48; c++) if (trace[c][33:29] !== 5'd0) bad = 1'b1;
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL filter_xid_zero got=nonzero exp=0");
      end
      vectors++;
      if (trace[55][4:0] !== 5'b11011) begin
         miscompares++;
         $display("FAIL ln_e8 got=%b exp=11011", trace[55][4:0]);
      end
      vectors++;
      if (PE_en !== 48'hffff_ffff_ffff || trace[56][40] !== 1'b0 || trace[57][40] !== 1'b1) begin
         miscompares++;
         $display("FAIL pe_en_done_e8 pe_en=%h done56=%b done57=%b exp all-ones,0,1",
                  PE_en, trace[56][40], trace[57][40]);
      end
   endtask

   task automatic test_map_e4_r2_t1;
      repeat (2) @(negedge clk);
      run_seq(4, 2, 1, 10'h13c, -1, -1);
      vectors++;
      if (PE_en !== 48'h0000_0000_0f0f) begin
         miscompares++;
         $display("FAIL pe_en_e4 got=%h exp=000000000f0f", PE_en);
      end
      vectors++;
      if (trace[1][38:19] !== 20'hfffff || trace[44][38:19] !== 20'hfffff) begin
         miscompares++;
         $display("FAIL xid_disabled got=%h/%h exp=fffff", trace[1][38:19], trace[44][38:19]);
      end
      vectors++;
      if (trace[49][17:6] !== 12'hfff || trace[52][17:6] !== 12'hfff) begin
         miscompares++;
         $display("FAIL yid_unused_rows got=%h/%h exp=fff", trace[49][17:6], trace[52][17:6]);
      end
      vectors++;
      if (trace[53][11:9] !== 3'd0 || trace[54][8:6] !== 3'd0) begin
         miscompares++;
         $display("FAIL psum_yids got ipsum1=%0d opsum0=%0d exp=0,0", trace[53][11:9], trace[54][8:6]);
      end
      vectors++;
      if (trace[55][4:0] !== 5'b00001) begin
         miscompares++;
         $display("FAIL ln_e4 got=%b exp=00001", trace[55][4:0]);
      end
   endtask

   task automatic test_restart_ignored;
      int n;
      repeat (2) @(negedge clk);
      run_seq(5, 2, 3, 10'h0f1, 20, -1);
      n = 0;
      for (int c = 1; c <= 48; c++) if (trace[c][39] === 1'b1) n++;
      vectors++;
      if (n != 48 || trace[57][40] !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_ignored set_xid_cycles=%0d done57=%b exp=48,1", n, trace[57][40]);
      end
   endtask

   task automatic test_mid_reset;
      repeat (2) @(negedge clk);
      run_seq(6, 2, 2, 10'h3e7, -1, 30);
      run_seq(7, 1, 5, 10'h155, -1, -1);
   endtask

   task automatic test_back_to_back;
      repeat (2) @(negedge clk);
      run_seq(3, 6, 1, 10'h0aa, -1, -1);
      run_seq(8, 1, 6, 10'h355, -1, -1);
   endtask

   task automatic test_random;
      for (int n = 0; n < 6; n++) begin
         int r, t, e;
         r = $urandom_range(1, 6);
         t = $urandom_range(1, 6 / r);
         e = $urandom_range(1, 8);
         repeat ($urandom_range(1, 3)) @(negedge clk);
         run_seq(e, r, t, 10'($urandom), -1, -1);
      end
   endtask

`ifdef PE_ARRAY_CFG_CHECK_EN
   task automatic test_cfg_error;
      int bad_e[3] = '{8, 0, 9};
      int bad_r[3] = '{4, 1, 1};
      int bad_t[3] = '{2, 1, 1};
      for (int n = 0; n < 3; n++) begin
         repeat (2) @(negedge clk);
         cfg_e = 4'(bad_e[n]); cfg_r = 3'(bad_r[n]); cfg_t = 3'(bad_t[n]);
         cfg_pe_config = 10'($urandom); start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         vectors++;
         if (error !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || set_XID !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_error_pulse n=%0d got err=%b done=%b busy=%b setx=%b exp 1,1,0,0",
                     n, error, done, busy, set_XID);
         end
         @(negedge clk);
         vectors++;
         if (error !== 1'b0 || done !== 1'b0 || obs !== 42'h0) begin
            miscompares++;
            $display("FAIL cfg_error_idle n=%0d got err=%b obs=%h exp 0,0", n, error, obs);
         end
         vectors++;
         if (PE_en !== prev_en || PE_config !== prev_cfg) begin
            miscompares++;
            $display("FAIL cfg_error_pe_hold got=%h/%h exp=%h/%h", PE_en, PE_config, prev_en, prev_cfg);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_map_e8_r3_t2();
      test_map_e4_r2_t1();
      test_restart_ignored();
      test_mid_reset();
      test_back_to_back();
      test_random();
`ifdef PE_ARRAY_CFG_CHECK_EN
      test_cfg_error();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
